// File: rtl/gate_resp_checker_if.sv
// ---------------------------------------------------------------------------
// gate_resp_checker_if
// Bundles the stimulus-side observation signals and the verdict outputs of
// gate_resp_checker.
//   start, in_valid, a, b, gate_out : driven by the master (stimulus/test side)
//   busy, done, pass, err_count, cov_mask, mismatch_bits, first_fail, overrun
//                                   : driven by the slave (the checker)
// CNT_W must equal the CNT_W of the checker instance connected to it.
// ---------------------------------------------------------------------------
interface gate_resp_checker_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic             in_valid;
   logic             a;
   logic             b;
   logic [7:0]       gate_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;
   logic [3:0]       cov_mask;
   logic [7:0]       mismatch_bits;
   logic [9:0]       first_fail;
   logic             overrun;

   modport master (
      output start, in_valid, a, b, gate_out,
      input  busy, done, pass, err_count, cov_mask, mismatch_bits, first_fail, overrun
   );

   modport slave (
      input  start, in_valid, a, b, gate_out,
      output busy, done, pass, err_count, cov_mask, mismatch_bits, first_fail, overrun
   );
endinterface

// File: rtl/gate_resp_checker.sv
// ---------------------------------------------------------------------------
// gate_resp_checker
// Response monitor for the two-input logic-gate block. Each applied vector
// {a,b} is captured on in_valid, the gate outputs are sampled SETTLE cycles
// later and compared with the ideal truth table. Errors accumulate until all
// four input combinations have been compared, then a pass/fail verdict holds.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - gate_resp_checker_if.slave: start, in_valid, a, b, gate_out in;
//            busy, done, pass, err_count, cov_mask, mismatch_bits,
//            first_fail, overrun out
// Parameters:
//   SETTLE - cycles between capture and sampling (0..15)
//   CNT_W  - width of the saturating error counter
// ---------------------------------------------------------------------------
module gate_resp_checker #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gate_resp_checker_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
   localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

   // Ideal outputs in gate_out bit order: and, or, not_a, not_b, nand, nor, xor, xnor.
   function automatic logic [7:0] ideal_gates(input logic x, input logic y);
      return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~y, ~x, x | y, x & y};
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             va_q, va_d;
   logic             vb_q, vb_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [3:0]       cov_mask_q, cov_mask_d;
   logic [7:0]       mismatch_q, mismatch_d;
   logic [9:0]       first_fail_q, first_fail_d;
   logic             overrun_q, overrun_d;
   logic             done_q, done_d;

   logic [7:0]       diff_s;
   logic [3:0]       cov_upd_s;

   // Next-state and result-update logic for the capture/settle/compare sequence.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      va_d         = va_q;
      vb_d         = vb_q;
      err_count_d  = err_count_q;
      cov_mask_d   = cov_mask_q;
      mismatch_d   = mismatch_q;
      first_fail_d = first_fail_q;
      overrun_d    = overrun_q;
      diff_s       = ideal_gates(va_q, vb_q) ^ bus.gate_out;
      cov_upd_s    = cov_mask_q | (4'b0001 << {va_q, vb_q});

      if (bus.start) begin
         // start wins over in_valid in any state; a coincident vector is dropped
         state_d      = ST_ARMED;
         cnt_d        = 4'd0;
         err_count_d  = '0;
         cov_mask_d   = 4'd0;
         mismatch_d   = 8'd0;
         first_fail_d = 10'd0;
         overrun_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_ARMED: begin
               if (bus.in_valid) begin
                  va_d  = bus.a;
                  vb_d  = bus.b;
                  cnt_d = SETTLE_L;
                  if (SETTLE_L == 4'd0) begin
                     state_d = ST_COMPARE;
                  end else begin
                     state_d = ST_SETTLE;
                  end
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_SETTLE: begin
               if (bus.in_valid) begin
                  overrun_d = 1'b1;
               end else begin
                  overrun_d = overrun_q;
               end
               // <= rather than == so a corrupted zero count cannot stall here
               if (cnt_q <= 4'd1) begin
                  cnt_d   = 4'd0;
                  state_d = ST_COMPARE;
               end else begin
                  cnt_d   = cnt_q - 4'd1;
                  state_d = ST_SETTLE;
               end
            end
            ST_COMPARE: begin
               if (bus.in_valid) begin
                  overrun_d = 1'b1;
               end else begin
                  overrun_d = overrun_q;
               end
               mismatch_d = diff_s;
               if (diff_s != 8'd0) begin
                  // first_fail only records the very first error since start
                  if (err_count_q == '0) begin
                     first_fail_d = {va_q, vb_q, bus.gate_out};
                  end else begin
                     first_fail_d = first_fail_q;
                  end
                  if (err_count_q != ERR_MAX) begin
                     err_count_d = err_count_q + CNT_W'(1);
                  end else begin
                     err_count_d = err_count_q;
                  end
               end else begin
                  first_fail_d = first_fail_q;
                  err_count_d  = err_count_q;
               end
               cov_mask_d = cov_upd_s;
               if (cov_upd_s == 4'hF) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ARMED;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      done_d = (state_d == ST_DONE);
   end

   // State and result registers; rst_n clears everything without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         va_q         <= 1'b0;
         vb_q         <= 1'b0;
         err_count_q  <= '0;
         cov_mask_q   <= 4'd0;
         mismatch_q   <= 8'd0;
         first_fail_q <= 10'd0;
         overrun_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         va_q         <= va_d;
         vb_q         <= vb_d;
         err_count_q  <= err_count_d;
         cov_mask_q   <= cov_mask_d;
         mismatch_q   <= mismatch_d;
         first_fail_q <= first_fail_d;
         overrun_q    <= overrun_d;
         done_q       <= done_d;
      end
   end

   assign bus.busy          = (state_q == ST_ARMED) || (state_q == ST_SETTLE) ||
                              (state_q == ST_COMPARE);
   assign bus.done          = done_q;
   assign bus.pass          = done_q & (err_count_q == '0);
   assign bus.err_count     = err_count_q;
   assign bus.cov_mask      = cov_mask_q;
   assign bus.mismatch_bits = mismatch_q;
   assign bus.first_fail    = first_fail_q;
   assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_resp_checker
// Two checker instances: u0 (SETTLE=2, CNT_W=8) and u1 (SETTLE=3, CNT_W=2).
// A transaction-level model tracks what each checker must report; one
// process compares every output of both instances on each falling edge,
// and the directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_gate_resp_checker;

   localparam int S0 = 2;
   localparam int S1 = 3;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus per instance
   logic       s_start [2];
   logic       s_iv    [2];
   logic       s_a     [2];
   logic       s_b     [2];
   logic [7:0] s_g     [2];

   gate_resp_checker_if #(.CNT_W(8)) if0 ();
   gate_resp_checker_if #(.CNT_W(2)) if1 ();

   assign if0.start    = s_start[0];
   assign if0.in_valid = s_iv[0];
   assign if0.a        = s_a[0];
   assign if0.b        = s_b[0];
   assign if0.gate_out = s_g[0];
   assign if1.start    = s_start[1];
   assign if1.in_valid = s_iv[1];
   assign if1.a        = s_a[1];
   assign if1.b        = s_b[1];
   assign if1.gate_out = s_g[1];

   gate_resp_checker #(.SETTLE(S0), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   gate_resp_checker #(.SETTLE(S1), .CNT_W(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   // observed outputs, widened to a common shape
   logic       o_busy [2];
   logic       o_done [2];
   logic       o_pass [2];
   logic       o_ovr  [2];
   logic [7:0] o_err  [2];
   logic [3:0] o_cov  [2];
   logic [7:0] o_mis  [2];
   logic [9:0] o_ff   [2];

   assign o_busy[0] = if0.busy;          assign o_busy[1] = if1.busy;
   assign o_done[0] = if0.done;          assign o_done[1] = if1.done;
   assign o_pass[0] = if0.pass;          assign o_pass[1] = if1.pass;
   assign o_ovr[0]  = if0.overrun;       assign o_ovr[1]  = if1.overrun;
   assign o_err[0]  = if0.err_count;     assign o_err[1]  = {6'd0, if1.err_count};
   assign o_cov[0]  = if0.cov_mask;      assign o_cov[1]  = if1.cov_mask;
   assign o_mis[0]  = if0.mismatch_bits; assign o_mis[1]  = if1.mismatch_bits;
   assign o_ff[0]   = if0.first_fail;    assign o_ff[1]   = if1.first_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // phase: 0 idle, 1 waiting for a vector, 2 vector pending, 3 verdict held
   int         m_phase [2];
   int         m_wait  [2];
   logic       m_va    [2];
   logic       m_vb    [2];
   int         m_err   [2];
   logic [3:0] m_cov   [2];
   logic [7:0] m_mis   [2];
   logic [9:0] m_ff    [2];
   logic       m_ovr   [2];

   // ideal truth table, indexed by {a,b}
   function automatic logic [7:0] gold(input int ab);
      case (ab)
         0:       return 8'hBC;
         1:       return 8'h56;
         2:       return 8'h5A;
         default: return 8'h83;
      endcase
   endfunction

   function automatic int settle_of(input int k);
      return (k == 0) ? S0 : S1;
   endfunction

   function automatic int errmax_of(input int k);
      return (k == 0) ? 255 : 3;
   endfunction

   task automatic model_clear(input int k);
      m_err[k] = 0; m_cov[k] = 4'd0; m_mis[k] = 8'd0; m_ff[k] = 10'd0; m_ovr[k] = 1'b0;
   endtask

   task automatic model_reset(input int k);
      model_clear(k);
      m_phase[k] = 0; m_wait[k] = 0; m_va[k] = 1'b0; m_vb[k] = 1'b0;
   endtask

   // advance the model by one rising edge using the inputs seen at that edge
   task automatic model_step(input int k);
      int ab;
      if (!rst_n) begin
         model_reset(k);
         return;
      end
      if (s_start[k]) begin
         model_clear(k);
         m_phase[k] = 1;
      end else if (m_phase[k] == 1) begin
         if (s_iv[k]) begin
            m_va[k]    = s_a[k];
            m_vb[k]    = s_b[k];
            m_wait[k]  = (settle_of(k) == 0) ? 1 : settle_of(k) + 1;
            m_phase[k] = 2;
         end
      end else if (m_phase[k] == 2) begin
         if (s_iv[k]) m_ovr[k] = 1'b1;
         m_wait[k]--;
         if (m_wait[k] == 0) begin
            ab       = (m_va[k] ? 2 : 0) + (m_vb[k] ? 1 : 0);
            m_mis[k] = gold(ab) ^ s_g[k];
            if (m_mis[k] != 8'd0) begin
               if (m_err[k] == 0) m_ff[k] = {m_va[k], m_vb[k], s_g[k]};
               if (m_err[k] < errmax_of(k)) m_err[k]++;
            end
            m_cov[k][ab] = 1'b1;
            m_phase[k]   = (m_cov[k] == 4'hF) ? 3 : 1;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_k(input int k);
      logic exp_done;
      exp_done = (m_phase[k] == 3);
      chk($sformatf("u%0d.busy", k), 32'(o_busy[k]), 32'(m_phase[k] == 1 || m_phase[k] == 2));
      chk($sformatf("u%0d.done", k), 32'(o_done[k]), 32'(exp_done));
      chk($sformatf("u%0d.pass", k), 32'(o_pass[k]), 32'(exp_done && m_err[k] == 0));
      chk($sformatf("u%0d.err_count", k), 32'(o_err[k]), 32'(m_err[k]));
      chk($sformatf("u%0d.cov_mask", k), 32'(o_cov[k]), 32'(m_cov[k]));
      chk($sformatf("u%0d.mismatch_bits", k), 32'(o_mis[k]), 32'(m_mis[k]));
      chk($sformatf("u%0d.first_fail", k), 32'(o_ff[k]), 32'(m_ff[k]));
      chk($sformatf("u%0d.overrun", k), 32'(o_ovr[k]), 32'(m_ovr[k]));
   endtask

   // model update on each rising edge, output comparison on each falling edge
   initial begin
      for (int k = 0; k < 2; k++) model_reset(k);
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) model_step(k);
         @(negedge clk);
         if (!rst_n) begin
            for (int k = 0; k < 2; k++) model_reset(k);
         end
         for (int k = 0; k < 2; k++) compare_k(k);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int k);
      s_start[k] = 1'b1;
      tick();
      s_start[k] = 1'b0;
   endtask

   // one in_valid pulse, gate_out held until the compare edge has passed
   task automatic vec(input int k, input logic va, input logic vb, input logic [7:0] g);
      s_iv[k] = 1'b1; s_a[k] = va; s_b[k] = vb; s_g[k] = g;
      tick();
      s_iv[k] = 1'b0;
      repeat (settle_of(k) + 1) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         s_start[k] = 1'b0; s_iv[k] = 1'b0; s_a[k] = 1'b0; s_b[k] = 1'b0; s_g[k] = 8'h00;
      end
      tick();
      chk("reset.busy", 32'(o_busy[0]), 32'd0);
      chk("reset.err_count", 32'(o_err[0]), 32'd0);
      chk("reset.first_fail", 32'(o_ff[1]), 32'd0);
      rst_n = 1'b1;
      tick();

      // golden sweep
      pulse_start(0);
      vec(0, 1'b0, 1'b0, 8'hBC);
      vec(0, 1'b0, 1'b1, 8'h56);
      vec(0, 1'b1, 1'b0, 8'h5A);
      vec(0, 1'b1, 1'b1, 8'h83);
      tick();
      chk("golden.done", 32'(o_done[0]), 32'd1);
      chk("golden.pass", 32'(o_pass[0]), 32'd1);
      chk("golden.cov_mask", 32'(o_cov[0]), 32'hF);
      chk("golden.overrun", 32'(o_ovr[0]), 32'd0);

      // xor output stuck at 0
      pulse_start(0);
      vec(0, 1'b0, 1'b0, 8'hBC);
      vec(0, 1'b0, 1'b1, 8'h16);
      vec(0, 1'b1, 1'b0, 8'h1A);
      chk("stuck.mismatch_bits", 32'(o_mis[0]), 32'h40);
      vec(0, 1'b1, 1'b1, 8'h83);
      tick();
      chk("stuck.err_count", 32'(o_err[0]), 32'd2);
      chk("stuck.pass", 32'(o_pass[0]), 32'd0);
      chk("stuck.first_fail", 32'(o_ff[0]), 32'h116);

      // coverage gating with repeated vectors
      pulse_start(0);
      vec(0, 1'b0, 1'b0, 8'hBC);
      vec(0, 1'b0, 1'b0, 8'hBC);
      vec(0, 1'b0, 1'b0, 8'hBC);
      vec(0, 1'b1, 1'b1, 8'h83);
      chk("cover.busy", 32'(o_busy[0]), 32'd1);
      chk("cover.cov_mask", 32'(o_cov[0]), 32'h9);
      chk("cover.done", 32'(o_done[0]), 32'd0);
      vec(0, 1'b0, 1'b1, 8'h56);
      vec(0, 1'b1, 1'b0, 8'h5A);
      tick();
      chk("cover.done_final", 32'(o_done[0]), 32'd1);
      chk("cover.cov_final", 32'(o_cov[0]), 32'hF);

      // overrun on the SETTLE=3 instance
      pulse_start(1);
      s_iv[1] = 1'b1; s_a[1] = 1'b1; s_b[1] = 1'b0; s_g[1] = 8'h5A;
      tick();
      s_iv[1] = 1'b0;
      tick();
      s_iv[1] = 1'b1; s_a[1] = 1'b0; s_b[1] = 1'b0;
      tick();
      s_iv[1] = 1'b0;
      repeat (3) tick();
      chk("ovr.overrun", 32'(o_ovr[1]), 32'd1);
      chk("ovr.cov_mask", 32'(o_cov[1]), 32'h4);
      chk("ovr.err_count", 32'(o_err[1]), 32'd0);

      // saturation with CNT_W=2 and outputs tied low, restarted while busy
      pulse_start(1);
      vec(1, 1'b0, 1'b0, 8'h00);
      vec(1, 1'b0, 1'b1, 8'h00);
      vec(1, 1'b1, 1'b0, 8'h00);
      vec(1, 1'b1, 1'b1, 8'h00);
      tick();
      chk("sat.err_count", 32'(o_err[1]), 32'd3);
      chk("sat.first_fail", 32'(o_ff[1]), 32'h000);
      chk("sat.done", 32'(o_done[1]), 32'd1);
      vec(1, 1'b0, 1'b0, 8'h00);
      vec(1, 1'b1, 1'b1, 8'h00);
      chk("sat.err_hold", 32'(o_err[1]), 32'd3);

      // asynchronous reset while u0 is settling
      pulse_start(0);
      s_iv[0] = 1'b1; s_a[0] = 1'b0; s_b[0] = 1'b0; s_g[0] = 8'hBC;
      tick();
      s_iv[0] = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst.busy", 32'(o_busy[0]), 32'd0);
      chk("arst.cov_mask", 32'(o_cov[0]), 32'd0);
      chk("arst.err_count_u1", 32'(o_err[1]), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      vec(0, 1'b1, 1'b1, 8'h83);
      chk("arst.ignored_cov", 32'(o_cov[0]), 32'd0);
      pulse_start(0);
      vec(0, 1'b1, 1'b1, 8'h00);
      chk("arst.err_after", 32'(o_err[0]), 32'd1);
      chk("arst.first_fail", 32'(o_ff[0]), 32'h300);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_resp_checker.md
# gate_resp_checker

Self-checking response monitor for the two-input logic-gate block. It receives each applied input vector {a,b} with a valid strobe and waits a programmable settle time. It then samples the eight gate outputs, compares them against the ideal truth table and accumulates errors until all four input combinations have been covered. It sits on the opposite end of the gate stimulus path and turns a waveform-only check into a pass/fail verdict usable in simulation or on an FPGA.

## Interface
- SETTLE, 2, clock cycles between capturing a vector and sampling gate outputs (0..15)
- CNT_W, 8, width of error counter (saturating)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; clears results and arms checker
- in_valid  input  1  a,b hold a new applied vector this cycle
- a  input  1  applied input a
- b  input  1  applied input b
- gate_out  input  8  DUT outputs: [0]and [1]or [2]not_a [3]not_b [4]nand [5]nor [6]xor [7]xnor
- busy  output  1  high in ARMED/SETTLE/COMPARE
- done  output  1  high in DONE
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  CNT_W  number of mismatching compares, saturates at all-ones
- cov_mask  output  4  bit {a,b} set once that combination has been compared
- mismatch_bits  output  8  XOR of expected vs sampled gate_out from most recent compare
- first_fail  output  10  {a,b,gate_out} of first failing compare since start; 0 if none
- overrun  output  1  sticky; in_valid seen while in SETTLE or COMPARE

## Operation
- Reset: state IDLE; all outputs 0.
- States: IDLE, ARMED, SETTLE, COMPARE, DONE.
- IDLE: waits for start. start -> ARMED; clears err_count, cov_mask, mismatch_bits, first_fail and overrun.
- ARMED: in_valid -> capture a,b into va,vb; reload settle counter with SETTLE; go to SETTLE, or straight to COMPARE if SETTLE==0.
- SETTLE: decrement the counter each cycle; at 1 -> COMPARE.
- COMPARE (one cycle):
  - expected = {~(va^vb), va^vb, ~(va|vb), ~(va&vb), ~vb, ~va, va|vb, va&vb}.
  - mismatch_bits <= expected ^ gate_out.
  - Nonzero mismatch: err_count increments (holds at max); first_fail loads {va,vb,gate_out} only if err_count was 0.
  - cov_mask[{va,vb}] <= 1.
  - Next state: DONE if the updated cov_mask == 4'hF, else ARMED.
- Repeated vectors are compared and counted normally; coverage just stays set.
- in_valid in SETTLE or COMPARE is ignored and sets overrun; the captured vector is unaffected.
- DONE: results hold. start -> clear and ARMED, same as from IDLE. start while busy restarts: clear and ARMED.
- pass = done & (err_count==0), combinational from registered state.
- rst_n low at any time returns to IDLE with all outputs 0 immediately, independent of clk.

## Timing
- in_valid sampled at edge t; with SETTLE=N≥1, gate_out is sampled at edge t+N+1; with N=0, at edge t+1.
- err_count, cov_mask, mismatch_bits and first_fail update on the COMPARE edge.
- done rises the cycle after the final compare edge. Next in_valid is accepted in ARMED: earliest at edge t+N+2.
- start takes priority over in_valid in the same cycle; that vector is dropped.
- All outputs are registered except pass and busy, which are decoded from state.

## Test plan
- Golden sweep, SETTLE=2: start; apply (0,0)/BC, (0,1)/56, (1,0)/5A, (1,1)/83 in order, each held ≥3 cycles -> done=1, pass=1, err_count=0, cov_mask=F, overrun=0.
- Stuck bit: same sweep but force gate_out[6]=0 -> xor mismatch on (0,1) and (1,0). Expect err_count=2, pass=0, first_fail={0,1,8'h16}, last mismatch_bits=8'h40.
- Coverage gating: apply (0,0) three times then (1,1) -> busy stays 1, cov_mask=9, done=0. Then apply (0,1) and (1,0) -> done=1, cov_mask=F.
- Overrun and settle: SETTLE=3; pulse in_valid with (1,0), pulse again 1 cycle later with (0,0) -> overrun=1. Compare occurs 4 edges after the first pulse using va,vb=1,0; cov_mask=4.
- Saturation: CNT_W=2, gate_out tied 0, sweep all four twice after a restart -> err_count holds 3; first_fail captured once = {0,0,8'h00}.
- Async reset mid-SETTLE: drop rst_n between clock edges -> outputs 0 and state IDLE immediately. in_valid is ignored until start; after start, results accumulate from zero.
